vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

VGA raster timing generator that drives the sync pins and tells the pixel stage which pixel is being scanned. Sits directly upstream of the rectangle-drawing pixel logic, on the post-clock-manager clock domain. Produces active-low hsync/vsync, the current pixel coordinates, an active-video qualifier and a frame-start strobe.

## Interface
- CLK_DIV, 2: system clocks per pixel (≥1); 2 gives 25 MHz pixels from 50 MHz.
- H_ACTIVE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal segments, in pixels.
- V_ACTIVE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical segments, in lines.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pixel_tick  out  1  one-clock pulse per pixel period.
- vga_hsync  out  1  horizontal sync, active low.
- vga_vsync  out  1  vertical sync, active low.
- pixel_x  out  10  current horizontal count (0..H_TOTAL-1).
- pixel_y  out  10  current vertical count (0..V_TOTAL-1).
- pixel_valid  out  1  high while pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
- frame_start  out  1  one-clock pulse when the raster enters (0,0).
- frame_count  out  16  frames started since reset (see Configuration).

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Divider: div counter 0..CLK_DIV-1; pixel_tick high in the cycle div == CLK_DIV-1, then div wraps to 0. CLK_DIV=1: pixel_tick constantly high after reset.
- On each clock edge where pixel_tick is high: h ← h+1; at h == H_TOTAL-1, h ← 0 and v ← v+1; at v == V_TOTAL-1 together with the h wrap, v ← 0.
- Reset loads h = H_TOTAL-1, v = V_TOTAL-1, div = 0, so the first tick after reset enters (0,0) and produces frame_start.
- hsync low iff H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC (656..751).
- vsync low iff V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC (490..491).
- All outputs are registered and computed from the next-state counters, so in any cycle they describe the h/v held in the counters that cycle; there is no skew between sync, coordinates and pixel_valid.
- frame_start is high for exactly one clock, the first cycle with (h,v) = (0,0); it is not held for the full pixel period.

## Timing
- Reset values: pixel_tick 0, vga_hsync 1, vga_vsync 1, pixel_x 0, pixel_y 0, pixel_valid 0, frame_start 0, frame_count 0.
- Reset assertion mid-frame: all outputs take reset values immediately (asynchronous), without waiting for a clock edge.
- After reset deassertion, the first pixel_tick comes CLK_DIV clocks later; outputs move to (0,0), pixel_valid 1 and frame_start 1 on that edge.
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clocks (840000 at defaults). Line period: H_TOTAL·CLK_DIV (1600).
- Coordinates and sync change only on tick edges; between ticks all outputs are held except pixel_tick and frame_start.
- The pixel stage consumes pixel_x/pixel_y/pixel_valid in the same cycle and registers its color; it delays sync by one pixel to stay aligned.

## Configuration
- VGA_SYNC_FRAME_COUNT_EN defined: frame_count increments by 1 (wrapping 65535→0) on every frame_start cycle.
- Not defined: no counter logic; frame_count is tied to 0.

## Test plan
- Reset then release, CLK_DIV=2 -> pixel_tick first high 2 clocks after release; pixel_x=0, pixel_y=0, pixel_valid=1, frame_start=1 for exactly 1 clock.
- Run one line -> pixel_valid high for 1280 clocks, vga_hsync low from pixel_x=656 through 751 (192 clocks), line repeats every 1600 clocks.
- Run one frame -> vga_vsync low for lines 490–491 (3200 clocks); next frame_start exactly 840000 clocks after the first; pixel_valid 0 for all y ≥ 480.
- CLK_DIV=1 -> pixel_tick constant 1, frame period 420000 clocks, hsync low 96 clocks.
- Assert reset at pixel (700, 300) -> outputs immediately 1/1/0/0/0/0; after release the sequence restarts from (0,0) as in the first scenario.
- With VGA_SYNC_FRAME_COUNT_EN, run 3 frames -> frame_count reads 1, 2, 3 at each frame_start; without the macro it stays 0.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen to the pixel stage.
// master drives the timing outputs. slave consumes them. No flow control: the pixel stage must keep up.
interface vga_sync_gen_if;
    logic        pixel_tick;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output pixel_tick, vga_hsync, vga_vsync, pixel_x, pixel_y,
               pixel_valid, frame_start, frame_count
    );
    modport slave (
        input  pixel_tick, vga_hsync, vga_vsync, pixel_x, pixel_y,
               pixel_valid, frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: sync pins, pixel coordinates, active-video qualifier and frame strobe.
// Latency: outputs are registered from the next-state counters and change together on tick edges.
// Backpressure: none; free-running. VGA_SYNC_FRAME_COUNT_EN enables the frame counter.
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic           clock,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [9:0]       pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic             tick;
    logic             pixel_tick_q, pixel_tick_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        tick          = (div_q == DIV_LAST);
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        h_d           = h_q;
        v_d           = v_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        pixel_valid_d = pixel_valid_q;
        pixel_tick_d  = tick;
        frame_start_d = 1'b0;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            // Output registers mirror the counters only on tick edges, so they
            // hold their reset values until the first pixel after reset.
            pixel_x_d     = h_d;
            pixel_y_d     = v_d;
            hsync_d       = !((h_d >= HS_LO) && (h_d < HS_HI));
            vsync_d       = !((v_d >= VS_LO) && (v_d < VS_HI));
            pixel_valid_d = (h_d < H_ACT) && (v_d < V_ACT);
            frame_start_d = (h_d == '0) && (v_d == '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_tick_q  <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_tick_q  <= pixel_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_start_d) frame_count_d = frame_count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) frame_count_q <= '0;
        else        frame_count_q <= frame_count_d;
    end

    assign vga.frame_count = frame_count_q;
`else
    assign vga.frame_count = '0;
`endif

    assign vga.pixel_tick  = pixel_tick_q;
    assign vga.vga_hsync   = hsync_q;
    assign vga.vga_vsync   = vsync_q;
    assign vga.pixel_x     = pixel_x_q;
    assign vga.pixel_y     = pixel_y_q;
    assign vga.pixel_valid = pixel_valid_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a reduced raster (15x8), CLK_DIV=2 (dut a) and CLK_DIV=1 (dut b).
// Expected values are hand-derived from the raster segment lengths below.
module tb_vga_sync_gen;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // H: 8 active, 2 front, 3 sync, 2 back -> 15 px, hsync low x=10..12
    // V: 4 active, 1 front, 2 sync, 1 back -> 8 lines, vsync low y=5..6
    vga_sync_gen_if a_if ();
    vga_sync_gen_if b_if ();

    vga_sync_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1))
        dut_a (.clock(clk), .reset(rst_n), .vga(a_if));

    vga_sync_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1))
        dut_b (.clock(clk), .reset(rst_n), .vga(b_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_tick"},  32'(a_if.pixel_tick),  0);
        check({tag, "_hs"},    32'(a_if.vga_hsync),   1);
        check({tag, "_vs"},    32'(a_if.vga_vsync),   1);
        check({tag, "_x"},     32'(a_if.pixel_x),     0);
        check({tag, "_y"},     32'(a_if.pixel_y),     0);
        check({tag, "_valid"}, 32'(a_if.pixel_valid), 0);
        check({tag, "_fs"},    32'(a_if.frame_start), 0);
        check({tag, "_fc"},    32'(a_if.frame_count), 0);
    endtask

    int a_fs_pos[$];
    int b_fs_pos[$];
    int a_fc_at_fs[$];
    int a_valid_line0, a_hs_line0, a_hs_first_x, a_hs_last_x;
    int a_valid_frame0, a_vs_frame0, a_valid_bad, b_tick_zero, b_hs_line0;
    int exp_fc1, exp_fc2, exp_fc3;
    bit found;

    initial begin
`ifdef VGA_SYNC_FRAME_COUNT_EN
        exp_fc1 = 1; exp_fc2 = 2; exp_fc3 = 3;
`else
        exp_fc1 = 0; exp_fc2 = 0; exp_fc3 = 0;
`endif
        a_valid_line0 = 0; a_hs_line0 = 0; a_hs_first_x = -1; a_hs_last_x = -1;
        a_valid_frame0 = 0; a_vs_frame0 = 0; a_valid_bad = 0; b_tick_zero = 0; b_hs_line0 = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        check("rst_b_tick", 32'(b_if.pixel_tick), 0);

        rst_n = 1'b1;
        @(negedge clk);
        // k counts negedges after the first post-release edge
        for (int k = 0; k <= 490; k++) begin
            if (k == 0) begin
                check("a_k0_tick", 32'(a_if.pixel_tick), 0);
                check("a_k0_fs",   32'(a_if.frame_start), 0);
                check("b_k0_fs",   32'(b_if.frame_start), 1);
                check("b_k0_valid", 32'(b_if.pixel_valid), 1);
            end
            if (k == 1) begin
                check("a_k1_tick",  32'(a_if.pixel_tick), 1);
                check("a_k1_x",     32'(a_if.pixel_x), 0);
                check("a_k1_y",     32'(a_if.pixel_y), 0);
                check("a_k1_valid", 32'(a_if.pixel_valid), 1);
                check("a_k1_hs",    32'(a_if.vga_hsync), 1);
            end
            if (k == 2) begin
                check("a_k2_fs",   32'(a_if.frame_start), 0);
                check("a_k2_tick", 32'(a_if.pixel_tick), 0);
                check("a_k2_x",    32'(a_if.pixel_x), 0);
            end
            if (k == 3) check("a_k3_x", 32'(a_if.pixel_x), 1);
            if (k == 31) begin
                check("a_line1_x",    32'(a_if.pixel_x), 0);
                check("a_line1_y",    32'(a_if.pixel_y), 1);
                check("a_line1_tick", 32'(a_if.pixel_tick), 1);
            end
            if (a_if.frame_start) begin
                a_fs_pos.push_back(k);
                a_fc_at_fs.push_back(int'(a_if.frame_count));
            end
            if (b_if.frame_start) b_fs_pos.push_back(k);
            if (k >= 1 && k <= 30) begin
                if (a_if.pixel_valid) a_valid_line0++;
                if (!a_if.vga_hsync) begin
                    a_hs_line0++;
                    if (a_hs_first_x < 0) a_hs_first_x = int'(a_if.pixel_x);
                    a_hs_last_x = int'(a_if.pixel_x);
                end
            end
            if (k >= 1 && k <= 240) begin
                if (a_if.pixel_valid) a_valid_frame0++;
                if (!a_if.vga_vsync) a_vs_frame0++;
            end
            if (a_if.pixel_valid && a_if.pixel_y >= 10'd4) a_valid_bad++;
            if (!b_if.pixel_tick) b_tick_zero++;
            if (k <= 14 && !b_if.vga_hsync) b_hs_line0++;
            @(negedge clk);
        end

        check("a_valid_line0", a_valid_line0, 16);
        check("a_hs_line0",    a_hs_line0, 6);
        check("a_hs_first_x",  a_hs_first_x, 10);
        check("a_hs_last_x",   a_hs_last_x, 12);
        check("a_valid_frame", a_valid_frame0, 64);
        check("a_vs_frame",    a_vs_frame0, 60);
        check("a_valid_bad",   a_valid_bad, 0);
        check("a_fs_count",    a_fs_pos.size(), 3);
        check("a_fs_period",   (a_fs_pos.size() > 1) ? a_fs_pos[1] : -1, 241);
        check("a_fs_third",    (a_fs_pos.size() > 2) ? a_fs_pos[2] : -1, 481);
        check("a_fc_1",        (a_fc_at_fs.size() > 0) ? a_fc_at_fs[0] : -1, exp_fc1);
        check("a_fc_2",        (a_fc_at_fs.size() > 1) ? a_fc_at_fs[1] : -1, exp_fc2);
        check("a_fc_3",        (a_fc_at_fs.size() > 2) ? a_fc_at_fs[2] : -1, exp_fc3);
        check("b_tick_zero",   b_tick_zero, 0);
        check("b_hs_line0",    b_hs_line0, 3);
        check("b_fs_count",    b_fs_pos.size(), 5);
        check("b_fs_period",   (b_fs_pos.size() > 1) ? b_fs_pos[1] : -1, 120);

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (a_if.pixel_x == 10'd11 && a_if.pixel_y == 10'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_found", 32'(found), 1);
        check("mid_hs_pre", 32'(a_if.vga_hsync), 0);

        #1 rst_n = 1'b0;
        #1;
        check_reset_a("mid_rst");
        check("mid_rst_b_x", 32'(b_if.pixel_x), 0);
        check("mid_rst_b_tick", 32'(b_if.pixel_tick), 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_a_tick", 32'(a_if.pixel_tick), 0);
        check("rel_a_fs",   32'(a_if.frame_start), 0);
        check("rel_b_fs",   32'(b_if.frame_start), 1);
        @(negedge clk);
        check("rel_a_tick2", 32'(a_if.pixel_tick), 1);
        check("rel_a_fs2",   32'(a_if.frame_start), 1);
        check("rel_a_x",     32'(a_if.pixel_x), 0);
        check("rel_a_y",     32'(a_if.pixel_y), 0);
        check("rel_a_valid", 32'(a_if.pixel_valid), 1);
        check("rel_a_fc",    32'(a_if.frame_count), exp_fc1);
        @(negedge clk);
        check("rel_a_fs3",   32'(a_if.frame_start), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
